// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: drives the program-counter load, the instruction
// memory request, and the decode-side instruction register.
module pc_sequencer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [32:1] currentAddress,
  output logic        PCWrite,
  output logic [32:1] newAddress,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [32:1] imem_rdata,
  input  logic        branch_taken,
  input  logic [32:1] branch_target,
  input  logic        stall_req,
  output logic [32:1] instr_out,
  output logic        instr_valid,
  output logic        flush,
  output logic [16:1] fetch_count
);

  typedef enum logic [1:0] {
    WAIT0   = 2'd0,
    FETCH   = 2'd1,
    STALL   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [32:1] instr_q, instr_d;
  logic [32:1] hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        valid_q, valid_d;
  logic [16:1] count_q, count_d;
  logic [32:1] seq_address;

  assign seq_address = currentAddress + 32'd4;

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= WAIT0;
      instr_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    // An undelivered cycle drops the valid flag unless decode is holding it.
    valid_d      = stall_req ? valid_q : 1'b0;
    count_d      = count_q;
    PCWrite      = 1'b0;
    newAddress   = seq_address;
    imem_req     = 1'b0;
    flush        = 1'b0;

    if (!Reset) begin
      case (state_q)
        WAIT0: begin
          state_d = FETCH;
        end
        FETCH: begin
          imem_req = 1'b1;
          if (branch_taken) begin
            state_d = imem_ready ? FETCH : DISCARD;
          end else if (imem_ready && stall_req) begin
            hold_d       = imem_rdata;
            hold_valid_d = 1'b1;
            state_d      = STALL;
          end else if (imem_ready) begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            count_d = count_q + 16'd1;
            PCWrite = 1'b1;
          end
        end
        STALL: begin
          if (branch_taken) begin
            state_d = FETCH;
          end else if (!stall_req) begin
            instr_d      = hold_q;
            valid_d      = hold_valid_q;
            hold_valid_d = 1'b0;
            count_d      = count_q + 16'd1;
            PCWrite      = 1'b1;
            state_d      = FETCH;
          end
        end
        DISCARD: begin
          // A redirect here still leaves the old response in flight unless it lands now.
          if (imem_ready) begin
            state_d = FETCH;
          end
        end
        default: begin
          state_d = WAIT0;
        end
      endcase

      if (branch_taken && state_q != WAIT0) begin
        PCWrite      = 1'b1;
        newAddress   = branch_target;
        flush        = 1'b1;
        valid_d      = 1'b0;
        hold_valid_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model of the fetch path.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [32:1] currentAddress;
  logic        PCWrite;
  logic [32:1] newAddress;
  logic        imem_req;
  logic        imem_ready;
  logic [32:1] imem_rdata;
  logic        branch_taken;
  logic [32:1] branch_target;
  logic        stall_req;
  logic [32:1] instr_out;
  logic        instr_valid;
  logic        flush;
  logic [16:1] fetch_count;

  int tests  = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .currentAddress (currentAddress),
    .PCWrite        (PCWrite),
    .newAddress     (newAddress),
    .imem_req       (imem_req),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall_req      (stall_req),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .flush          (flush),
    .fetch_count    (fetch_count)
  );

  // Model: a parked-word queue, a count of responses still to drop, and the
  // decode-side view (valid, word, delivered count).
  bit          started;
  logic [31:0] hold_model[$];
  int          drop_n;
  bit          m_valid;
  logic [31:0] m_out;
  logic [15:0] m_count;

  bit          mem_busy;
  int          mem_wait;
  int          mem_lat;
  bit          mem_poison;
  logic [31:0] mem_addr;
  logic [31:0] pc;

  logic        last_req, last_pcw, last_flush;
  logic [31:0] last_na;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk1({tag, "_instr_valid"}, instr_valid, m_valid);
    chk32({tag, "_instr_out"}, instr_out, m_out);
    chk32({tag, "_fetch_count"}, {16'd0, fetch_count}, {16'd0, m_count});
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the model across the edge, then check registered outputs.
  task automatic applyStimulus(input bit rst, input bit br, input logic [31:0] tgt, input bit st);
    logic        e_req, e_pcw, e_flush, rdy;
    logic [31:0] e_na, rdata, n_out;
    logic [15:0] n_count;
    bit          n_started, n_valid, do_push, do_pop, do_clear;
    int          n_drop;

    Reset          = rst;
    branch_taken   = br;
    branch_target  = tgt;
    stall_req      = st;
    currentAddress = pc;

    if (rst) begin
      started  = 1'b0;
      hold_model.delete();
      drop_n   = 0;
      m_valid  = 1'b0;
      m_out    = '0;
      m_count  = '0;
      mem_busy = 1'b0;
    end

    e_req = !rst && started && hold_model.size() == 0 && drop_n == 0;
    if (e_req && !mem_busy) begin
      mem_busy = 1'b1;
      mem_addr = pc;
      mem_wait = mem_lat;
    end
    rdy   = !rst && mem_busy && mem_wait == 0;
    rdata = rdy ? (mem_poison ? 32'hDEAD_BEEF : memWord(mem_addr)) : $urandom();
    imem_ready = rdy;
    imem_rdata = rdata;

    n_started = started;
    n_valid   = st ? m_valid : 1'b0;
    n_out     = m_out;
    n_count   = m_count;
    n_drop    = drop_n;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_clear  = 1'b0;
    e_pcw     = 1'b0;
    e_flush   = 1'b0;
    e_na      = pc + 32'd4;

    if (rst) begin
      n_valid = 1'b0;
    end else if (!started) begin
      n_started = 1'b1;
    end else if (br) begin
      e_pcw    = 1'b1;
      e_na     = tgt;
      e_flush  = 1'b1;
      n_valid  = 1'b0;
      do_clear = 1'b1;
      if (drop_n > 0) begin
        if (rdy) n_drop = 0;
      end else if (hold_model.size() == 0 && !rdy) begin
        n_drop = 1;
      end
    end else if (hold_model.size() != 0) begin
      if (!st) begin
        do_pop  = 1'b1;
        n_out   = hold_model[0];
        n_valid = 1'b1;
        n_count = m_count + 16'd1;
        e_pcw   = 1'b1;
      end
    end else if (drop_n > 0) begin
      if (rdy) n_drop = drop_n - 1;
    end else if (rdy && st) begin
      do_push = 1'b1;
    end else if (rdy) begin
      n_out   = rdata;
      n_valid = 1'b1;
      n_count = m_count + 16'd1;
      e_pcw   = 1'b1;
    end

    #2;
    last_req   = imem_req;
    last_pcw   = PCWrite;
    last_flush = flush;
    last_na    = newAddress;
    chk1("imem_req", imem_req, e_req);
    chk1("PCWrite", PCWrite, e_pcw);
    chk1("flush", flush, e_flush);
    if (!rst) chk32("newAddress", newAddress, e_na);
    checkOutput("mid");

    @(posedge CLK);
    #1;
    started = n_started;
    m_valid = n_valid;
    m_out   = n_out;
    m_count = n_count;
    drop_n  = n_drop;
    if (do_clear) hold_model.delete();
    if (do_pop) void'(hold_model.pop_front());
    if (do_push) hold_model.push_back(rdata);
    if (rdy) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (!rst && e_pcw) pc = e_na;
    checkOutput("post");
  endtask

  initial begin
    pc         = '0;
    mem_lat    = 0;
    mem_poison = 1'b0;
    mem_busy   = 1'b0;
    mem_wait   = 0;
    mem_addr   = '0;
    started    = 1'b0;
    drop_n     = 0;
    m_valid    = 1'b0;
    m_out      = '0;
    m_count    = '0;

    // Reset outranks a simultaneous redirect.
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1);
    chk1("rst_pcwrite", last_pcw, 1'b0);
    chk1("rst_flush", last_flush, 1'b0);
    chk1("rst_req", last_req, 1'b0);

    // Zero-wait fetch stream from 0x100.
    pc = 32'h100;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("wait0_req", last_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("seq_na0", last_na, 32'h104);
    chk1("seq_valid_edge2", instr_valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("seq_na1", last_na, 32'h108);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("seq_na2", last_na, 32'h10C);
    chk32("seq_count3", {16'd0, fetch_count}, 32'd3);
    chk32("seq_word", instr_out, memWord(32'h108));

    // Two wait cycles on the memory.
    mem_lat = 2;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("wait_pcw0", last_pcw, 1'b0);
    chk1("wait_req0", last_req, 1'b1);
    chk32("wait_na0", last_na, 32'h110);
    chk1("wait_valid0", instr_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("wait_pcw1", last_pcw, 1'b0);
    chk1("wait_req1", last_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("wait_done_pcw", last_pcw, 1'b1);
    mem_lat = 0;

    // Stall coincident with a response, held three cycles.
    mem_poison = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    mem_poison = 1'b0;
    chk1("stall_pcw0", last_pcw, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("stall_pcw1", last_pcw, 1'b0);
    chk1("stall_req1", last_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("stall_pcw2", last_pcw, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("release_pcw", last_pcw, 1'b1);
    chk32("release_na", last_na, 32'h114);
    chk32("release_word", instr_out, 32'hDEAD_BEEF);
    chk32("release_count", {16'd0, fetch_count}, 32'd5);

    // Redirect to 0x200 while a fetch is outstanding.
    mem_lat = 2;
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
    mem_lat = 0;
    chk1("br_flush", last_flush, 1'b1);
    chk32("br_na", last_na, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("br_flush_once", last_flush, 1'b0);
    chk1("discard_req", last_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("drop_count", {16'd0, fetch_count}, 32'd5);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("br_word", instr_out, memWord(32'h200));
    chk32("br_count", {16'd0, fetch_count}, 32'd6);

    // Reset pulse while stalled.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    chk32("rststall_count", {16'd0, fetch_count}, 32'd0);
    chk1("rststall_valid", instr_valid, 1'b0);
    chk32("rststall_word", instr_out, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("rststall_wait0", last_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("rststall_req", last_req, 1'b1);

    // Address wrap at the top of memory.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    pc = 32'hFFFF_FFFC;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("addr_wrap", last_na, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      mem_lat = $urandom_range(0, 2);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                    $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0);
    end

    // Delivered-count wrap.
    mem_lat = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    pc = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk32("count_ffff", {16'd0, fetch_count}, 32'h0000_FFFF);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("count_wrap", {16'd0, fetch_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge clock.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port currentAddress  input  [32:1]  fetch address held by the program-counter register.
REQ-004 SHALL have port PCWrite  output  1  program-counter load enable.
REQ-005 SHALL have port newAddress  output  [32:1]  next program-counter value.
REQ-006 SHALL have port imem_req  output  1  instruction-memory read request; imem_addr is currentAddress.
REQ-007 SHALL have port imem_ready  input  1  instruction-memory response valid, one cycle per request.
REQ-008 SHALL have port imem_rdata  input  [32:1]  instruction word, valid when imem_ready=1.
REQ-009 SHALL have port branch_taken  input  1  redirect request from execute stage.
REQ-010 SHALL have port branch_target  input  [32:1]  redirect address.
REQ-011 SHALL have port stall_req  input  1  hazard stall from decode.
REQ-012 SHALL have port instr_out  output  [32:1]  registered instruction to decode.
REQ-013 SHALL have port instr_valid  output  1  instr_out holds a live instruction.
REQ-014 SHALL have port flush  output  1  one-cycle pulse killing younger pipeline contents.
REQ-015 SHALL have port fetch_count  output  [16:1]  number of instructions delivered.

Function
REQ-016 SHALL implement states WAIT0, FETCH, STALL and DISCARD.
REQ-017 WAIT0: imem_req=0, PCWrite=0; always go to FETCH next cycle.
REQ-018 FETCH: imem_req=1 every cycle; the request is outstanding until imem_ready=1.
REQ-019 FETCH with imem_ready=1, stall_req=0, branch_taken=0: PCWrite=1; newAddress=currentAddress+4 modulo 2^32; instr_out<=imem_rdata; instr_valid<=1; fetch_count increments; remain in FETCH.
REQ-020 FETCH with imem_ready=1, stall_req=1, branch_taken=0: PCWrite=0; imem_rdata is captured into an internal hold register; go to STALL.
REQ-021 STALL: imem_req=0; PCWrite=0; instr_out and instr_valid unchanged; when stall_req=0, load instr_out from the hold register, set instr_valid=1, set PCWrite=1 with newAddress=currentAddress+4, increment fetch_count, and go to FETCH.
REQ-022 branch_taken=1 in any state except WAIT0: PCWrite=1; newAddress=branch_target; flush=1 combinationally that cycle; instr_valid<=0; the hold register is invalidated.
REQ-023 branch_taken in FETCH with imem_ready=0 (request outstanding): go to DISCARD; otherwise go to FETCH.
REQ-024 DISCARD: imem_req=0; the next imem_ready response is dropped, with no instr_out update and no count change; then go to FETCH.
REQ-025 Priority SHALL be Reset > branch_taken > stall_req > normal fetch.
REQ-026 newAddress SHALL equal currentAddress+4 whenever PCWrite=0.
REQ-027 When a fetch is not delivered in a given cycle (imem_ready=0, or stall with no release), instr_valid SHALL fall to 0 on the next edge unless stall_req=1, in which case it holds.
REQ-028 fetch_count SHALL wrap from 16'hFFFF to 0 without a flag.
REQ-029 Address arithmetic SHALL be 32-bit unsigned; 32'hFFFFFFFC+4 SHALL produce 0.
REQ-030 branch_taken and stall_req asserted together SHALL perform the redirect and ignore the stall.

Reset
REQ-031 Reset=1 SHALL immediately force state=WAIT0, PCWrite=0, imem_req=0, flush=0, instr_valid=0, instr_out=0, fetch_count=0, and clear the hold register.
REQ-032 Reset asserted mid-fetch or mid-stall SHALL abandon the operation; after deassertion the first imem_req SHALL occur one cycle later, in WAIT0 then FETCH.
REQ-033 During Reset, newAddress SHALL be don't-care; the program-counter register ignores it.

Verification
REQ-034 Zero-wait memory with currentAddress=0x100, then 0x104 and 0x108 -> PCWrite=1 every FETCH cycle, newAddress 0x104/0x108/0x10C, instr_valid=1 from the second edge, fetch_count=3 after three responses.
REQ-035 imem_ready delayed 2 cycles -> PCWrite=0 and imem_req=1 for those cycles, instr_valid=0, newAddress=currentAddress+4.
REQ-036 stall_req=1 for 3 cycles coincident with a response 0xDEADBEEF -> PCWrite=0 for 3 cycles; on release instr_out=0xDEADBEEF, PCWrite=1 once, fetch_count +1.
REQ-037 branch_taken with target 0x200 while a fetch is outstanding -> flush=1 for one cycle, newAddress=0x200, the late response is dropped, and the next delivered instruction comes from 0x200.
REQ-038 Reset pulse while in STALL -> all outputs zero, a one-cycle WAIT0, then imem_req=1.
REQ-039 fetch_count preloaded by 65536 deliveries -> reads 0; currentAddress=0xFFFFFFFC -> newAddress=0.
